// File: rtl/rfm_pkg.sv
// ---------------------------------------------------------------------------
// rfm_pkg
// Shared defaults and the scheduler state type for the RFM scheduler slice.
//   NUM_ENTRY_DEF : number of tracked row counters
//   CNT_SIZE_DEF  : width of each row counter
//   IDX_W_DEF     : width of a row index
//   RAAIMT_DEF    : rolling-activation threshold that raises an RFM request
//   RAA_W_DEF     : width of the rolling activation counter
//   rfm_state_e   : IDLE / SCAN / ISSUE
// ---------------------------------------------------------------------------
package rfm_pkg;

  localparam int NUM_ENTRY_DEF = 64;
  localparam int CNT_SIZE_DEF  = 32;
  localparam int IDX_W_DEF     = 6;
  localparam int RAAIMT_DEF    = 32;
  localparam int RAA_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } rfm_state_e;

endpackage

// File: rtl/rfm_cnt_table.sv
// ---------------------------------------------------------------------------
// rfm_cnt_table
// Array of saturating per-row activation counters.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears all)
//   inc_en, inc_idx   : increment port, one row per cycle, saturates
//   clr_en, clr_idx   : clear port, one row per cycle
//   rd_idx, rd_cnt    : combinational read of the registered counter value
// A clear and an increment to the same row in one cycle leave the row at 1:
// the clear happens first and the activation is still counted.
// ---------------------------------------------------------------------------
module rfm_cnt_table
  import rfm_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_ENTRY_DEF,
  parameter int CNT_SIZE  = CNT_SIZE_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_en,
  input  logic [IDX_W-1:0]    inc_idx,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    clr_idx,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CNT_SIZE-1:0] rd_cnt
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

  logic [CNT_SIZE-1:0] cnt [NUM_ENTRY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (inc_en && (inc_idx == IDX_W'(i))) begin
          if (clr_en && (clr_idx == IDX_W'(i))) begin
            cnt[i] <= CNT_SIZE'(1);
          end else if (cnt[i] != CNT_MAX) begin
            cnt[i] <= cnt[i] + CNT_SIZE'(1);
          end
        end else if (clr_en && (clr_idx == IDX_W'(i))) begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/rfm_sched.sv
// ---------------------------------------------------------------------------
// rfm_sched
// Tracks per-row activations and a rolling activation count (raa). When raa
// reaches RAAIMT an RFM slot is requested; once granted, all counters are
// scanned one per cycle to find the hottest row (lowest index wins ties),
// which is offered as the mitigation target. Accepting it clears that row
// and retires RAAIMT from raa.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   act_valid, act_idx   : one row activation per cycle
//   rfm_req, rfm_grant   : slot request (registered) / grant (sampled only
//                          while rfm_req=1)
//   mit_valid, mit_idx,
//   mit_cnt, mit_ready   : mitigation target output channel
//   busy                 : 1 whenever the scheduler is not IDLE
//   mit_total            : 16-bit wrapping count of accepted mitigations,
//                          present only with RFM_SCHED_STAT_EN defined
//   state_dbg            : current scheduler state (rfm_state_e encoding)
// Handshake: the mitigation channel follows valid/ready. mit_valid rises
// with a target and stays up, with mit_idx/mit_cnt frozen, until a cycle
// where mit_valid and mit_ready are both 1; that cycle is the transfer.
// mit_idx/mit_cnt read 0 whenever mit_valid is 0.
// Optional feature macro: RFM_SCHED_STAT_EN.
// ---------------------------------------------------------------------------
module rfm_sched
  import rfm_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_ENTRY_DEF,
  parameter int CNT_SIZE  = CNT_SIZE_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int RAAIMT    = RAAIMT_DEF,
  parameter int RAA_W     = RAA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act_valid,
  input  logic [IDX_W-1:0]    act_idx,
  output logic                rfm_req,
  input  logic                rfm_grant,
  output logic                mit_valid,
  output logic [IDX_W-1:0]    mit_idx,
  output logic [CNT_SIZE-1:0] mit_cnt,
  input  logic                mit_ready,
  output logic                busy,
`ifdef RFM_SCHED_STAT_EN
  output logic [15:0]         mit_total,
`endif
  output logic [1:0]          state_dbg
);

  localparam logic [RAA_W-1:0] RAA_MAX = '1;
  localparam logic [RAA_W-1:0] RAA_TH  = RAA_W'(RAAIMT);
  localparam logic [IDX_W-1:0] PTR_END = IDX_W'(NUM_ENTRY - 1);

  rfm_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    best_idx;
  logic [CNT_SIZE-1:0] best_cnt;
  logic [RAA_W-1:0]    raa;
  logic [RAA_W-1:0]    raa_base;
  logic [RAA_W-1:0]    raa_nxt;
  logic [CNT_SIZE-1:0] rd_cnt;

  logic                hs;
  logic                scan_last;
  logic                cand_win;
  logic [CNT_SIZE-1:0] cand_cnt;
  logic [IDX_W-1:0]    cand_idx;
  logic                done;

  rfm_cnt_table #(
    .NUM_ENTRY (NUM_ENTRY),
    .CNT_SIZE  (CNT_SIZE),
    .IDX_W     (IDX_W)
  ) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (act_valid),
    .inc_idx (act_idx),
    .clr_en  (hs),
    .clr_idx (mit_idx),
    .rd_idx  (ptr),
    .rd_cnt  (rd_cnt)
  );

  assign hs        = (state == ST_ISSUE) && mit_valid && mit_ready;
  assign scan_last = (state == ST_SCAN) && (ptr == PTR_END);

  // Strict compare keeps the earlier (lower) index on ties.
  assign cand_win = (rd_cnt > best_cnt);
  assign cand_cnt = cand_win ? rd_cnt : best_cnt;
  assign cand_idx = cand_win ? ptr : best_idx;

  // A mitigation round ends either at the accepted transfer or at the end
  // of a scan that found nothing to mitigate.
  assign done = hs || (scan_last && (cand_cnt == '0));

  // Retire RAAIMT first, then count this cycle's activation on top.
  always_comb begin
    raa_base = raa;
    if (done) begin
      raa_base = (raa >= RAA_TH) ? (raa - RAA_TH) : '0;
    end
    raa_nxt = raa_base;
    if (act_valid && (raa_base != RAA_MAX)) begin
      raa_nxt = raa_base + RAA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      raa       <= '0;
      ptr       <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      rfm_req   <= 1'b0;
      mit_valid <= 1'b0;
      mit_idx   <= '0;
      mit_cnt   <= '0;
    end else begin
      raa <= raa_nxt;
      case (state)
        ST_IDLE: begin
          if (rfm_req && rfm_grant) begin
            rfm_req  <= 1'b0;
            state    <= ST_SCAN;
            ptr      <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end else if (!rfm_req && (raa_nxt >= RAA_TH)) begin
            // Raised together with the raa update that crosses the
            // threshold, so it is visible the cycle after that activation.
            rfm_req <= 1'b1;
          end
        end
        ST_SCAN: begin
          best_idx <= cand_idx;
          best_cnt <= cand_cnt;
          ptr      <= ptr + IDX_W'(1);
          if (scan_last) begin
            ptr      <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            if (cand_cnt != '0) begin
              state     <= ST_ISSUE;
              mit_valid <= 1'b1;
              mit_idx   <= cand_idx;
              mit_cnt   <= cand_cnt;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            mit_valid <= 1'b0;
            mit_idx   <= '0;
            mit_cnt   <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RFM_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mit_total <= '0;
    end else if (hs) begin
      mit_total <= mit_total + 16'd1;
    end
  end
`endif

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rfm_sched.sv
// ---------------------------------------------------------------------------
// tb_rfm_sched
// Bench for rfm_sched with default parameters. A behavioural model tracks
// counters, raa and the request/scan/issue round in plain integers; a compare
// process checks the DUT against it on every falling edge. Directed scenarios
// pin the model with literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_rfm_sched;

  localparam int  N       = 64;
  localparam int  TH      = 32;
  localparam int  RAA_MAX = 255;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        act_valid;
  logic [5:0]  act_idx;
  logic        rfm_req;
  logic        rfm_grant;
  logic        mit_valid;
  logic [5:0]  mit_idx;
  logic [31:0] mit_cnt;
  logic        mit_ready;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  rfm_sched dut (
    .clk       (clk),
    .rst       (rst),
    .act_valid (act_valid),
    .act_idx   (act_idx),
    .rfm_req   (rfm_req),
    .rfm_grant (rfm_grant),
    .mit_valid (mit_valid),
    .mit_idx   (mit_idx),
    .mit_cnt   (mit_cnt),
    .mit_ready (mit_ready),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for a grant, 1 = scanning entry m_k, 2 = offering target
  longint m_cnt [N];
  int     m_raa;
  bit     m_req;
  bit     m_mv;
  int     m_mi;
  longint m_mc;
  int     m_mode;
  int     m_k;
  longint m_bc;
  int     m_bi;

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_raa = 0; m_req = 0; m_mv = 0; m_mi = 0; m_mc = 0;
    m_mode = 0; m_k = 0; m_bc = 0; m_bi = 0;
  end

  always @(posedge clk) begin
    int old_mode;
    bit old_req;
    bit done;
    int clr;
    old_mode = m_mode;
    old_req  = m_req;
    done     = 1'b0;
    clr      = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_raa = 0; m_req = 0; m_mv = 0; m_mi = 0; m_mc = 0;
      m_mode = 0; m_k = 0; m_bc = 0; m_bi = 0;
    end else begin
      if (m_mode == 0) begin
        if (m_req && rfm_grant) begin
          m_req = 0; m_mode = 1; m_k = 0; m_bc = 0; m_bi = 0;
        end
      end else if (m_mode == 1) begin
        if (m_cnt[m_k] > m_bc) begin
          m_bc = m_cnt[m_k];
          m_bi = m_k;
        end
        if (m_k == N - 1) begin
          if (m_bc > 0) begin
            m_mode = 2; m_mv = 1; m_mi = m_bi; m_mc = m_bc;
          end else begin
            m_mode = 0; done = 1'b1;
          end
        end else begin
          m_k++;
        end
      end else begin
        if (mit_ready) begin
          clr = m_mi;
          m_mv = 0; m_mi = 0; m_mc = 0; m_mode = 0; done = 1'b1;
        end
      end
      if (clr >= 0) m_cnt[clr] = 0;
      if (act_valid && (m_cnt[int'(act_idx)] < CNT_MAX)) m_cnt[int'(act_idx)]++;
      if (done) m_raa = (m_raa > TH) ? (m_raa - TH) : 0;
      if (act_valid && (m_raa < RAA_MAX)) m_raa++;
      if ((old_mode == 0) && !old_req && (m_raa >= TH)) m_req = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rfm_req",   64'(rfm_req),   64'(m_req));
      chk("mit_valid", 64'(mit_valid), 64'(m_mv));
      chk("mit_idx",   64'(mit_idx),   64'(m_mi));
      chk("mit_cnt",   64'(mit_cnt),   64'(m_mc));
      chk("busy",      64'(busy),      64'(m_mode != 0));
      chk("state",     64'(state_dbg), 64'(m_mode));
      chk("raa",       64'(dut.raa),   64'(m_raa));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet();
    act_valid = 1'b0; rfm_grant = 1'b0; mit_ready = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_act(input int idx);
    act_valid = 1'b1;
    act_idx   = 6'(idx);
    step();
    act_valid = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc);
    int n = 0;
    while (!rfm_req && (n < max_cyc)) begin
      step();
      n++;
    end
    chk("req_wait", 64'(rfm_req), 64'd1);
  endtask

  task automatic wait_mv(input int max_cyc);
    int n = 0;
    while (!mit_valid && (n < max_cyc)) begin
      step();
      n++;
    end
    chk("mv_wait", 64'(mit_valid), 64'd1);
  endtask

  task automatic grant_once();
    rfm_grant = 1'b1;
    step();
    rfm_grant = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst = 1'b1;
    act_idx = '0;
    quiet();
    step();
    step();
    chk_on = 1'b1;
    // reset state
    chk("rst_req",  64'(rfm_req),   64'd0);
    chk("rst_mv",   64'(mit_valid), 64'd0);
    chk("rst_idx",  64'(mit_idx),   64'd0);
    chk("rst_cnt",  64'(mit_cnt),   64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    rst = 1'b0;

    // threshold: 31 acts keep req low, 32nd raises it next cycle
    for (int i = 0; i < 31; i++) do_act(5);
    chk("req_31", 64'(rfm_req), 64'd0);
    do_act(5);
    chk("req_32", 64'(rfm_req), 64'd1);

    // hottest row selection with a tie between 5 and 9
    do_reset();
    for (int i = 0; i < 20; i++) do_act(5);
    for (int i = 0; i < 20; i++) do_act(9);
    for (int i = 0; i < 7; i++)  do_act(40);
    chk("req_47", 64'(rfm_req), 64'd1);
    grant_once();                              // edge ending T
    chk("scan_req_low", 64'(rfm_req), 64'd0);
    for (int i = 0; i < 63; i++) step();       // 64 edges after T began
    chk("mv_T64",  64'(mit_valid), 64'd0);
    chk("busy_T64", 64'(busy),     64'd1);
    step();                                    // T+65
    chk("mv_T65",  64'(mit_valid), 64'd1);
    chk("idx_T65", 64'(mit_idx),   64'd5);
    chk("cnt_T65", 64'(mit_cnt),   64'd20);

    // consumer stalls for 10 cycles; target must hold
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_idx", 64'(mit_idx), 64'd5);
      chk("hold_cnt", 64'(mit_cnt), 64'd20);
    end
    // accept while row 5 is activated in the same cycle
    mit_ready = 1'b1; act_valid = 1'b1; act_idx = 6'd5;
    step();
    quiet();
    chk("hs_mv",   64'(mit_valid),         64'd0);
    chk("cnt5",    64'(dut.u_tbl.cnt[5]),  64'd1);
    chk("cnt9",    64'(dut.u_tbl.cnt[9]),  64'd20);
    chk("raa_hs",  64'(dut.raa),           64'd16);

    // empty scan: row 0 reaches 64, is mitigated, leaving raa=32 and all zero
    do_reset();
    for (int i = 0; i < 64; i++) do_act(0);
    wait_req(4);
    grant_once();
    wait_mv(70);
    chk("mv0_idx", 64'(mit_idx), 64'd0);
    chk("mv0_cnt", 64'(mit_cnt), 64'd64);
    mit_ready = 1'b1;
    step();
    mit_ready = 1'b0;
    chk("raa_32", 64'(dut.raa), 64'd32);
    wait_req(4);
    grant_once();
    seen = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (mit_valid) seen++;
    end
    chk("empty_busy64", 64'(busy), 64'd1);
    step();
    chk("empty_busy65", 64'(busy),      64'd0);
    chk("empty_state",  64'(state_dbg), 64'd0);
    chk("empty_raa",    64'(dut.raa),   64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (mit_valid) seen++;
    end
    chk("empty_no_mv", 64'(seen), 64'd0);

    // reset in the middle of a scan
    do_reset();
    for (int i = 0; i < 40; i++) do_act(7);
    wait_req(4);
    grant_once();                              // now at T+1
    for (int i = 0; i < 29; i++) step();       // now at T+30
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req",  64'(rfm_req),   64'd0);
    chk("abort_mv",   64'(mit_valid), 64'd0);
    chk("abort_idx",  64'(mit_idx),   64'd0);
    chk("abort_cnt",  64'(mit_cnt),   64'd0);
    chk("abort_busy", 64'(busy),      64'd0);
    chk("abort_c7",   64'(dut.u_tbl.cnt[7]), 64'd0);
    seen = 0;
    mit_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (mit_valid) seen++;
    end
    mit_ready = 1'b0;
    chk("abort_no_mv", 64'(seen), 64'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      act_valid = ($urandom_range(0, 99) < 70);
      act_idx   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 7));
      rfm_grant = ($urandom_range(0, 3) == 0);
      mit_ready = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0;
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfm_sched.md
RFM_SCHED -- requirements
Module: rfm_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 64, the number of tracked row counters.
REQ-002 SHALL have parameter CNT_SIZE, default 32, the width of each row counter.
REQ-003 SHALL have parameter IDX_W, default 6, the width of a row index (clog2 NUM_ENTRY).
REQ-004 SHALL have parameter RAAIMT, default 32, the activation threshold that triggers an RFM request.
REQ-005 SHALL have parameter RAA_W, default 8, the width of the rolling activation counter.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port act_valid, input, 1, which flags one row activation this cycle.
REQ-009 SHALL have port act_idx, input, IDX_W, the index of the activated row.
REQ-010 SHALL have port rfm_req, output, 1, registered; it requests an RFM slot.
REQ-011 SHALL have port rfm_grant, input, 1, which grants the slot and is sampled only while rfm_req=1.
REQ-012 SHALL have port mit_valid, output, 1, which flags that the mitigation target is valid.
REQ-013 SHALL have port mit_idx, output, IDX_W, the index of the hottest row.
REQ-014 SHALL have port mit_cnt, output, CNT_SIZE, the count of that row at selection.
REQ-015 SHALL have port mit_ready, input, 1, the consumer accept; a transfer occurs when mit_valid and mit_ready are both 1.
REQ-016 SHALL have port busy, output, 1, which is 1 whenever the state is not IDLE.

Function
REQ-017 SHALL increment cnt[act_idx] by 1 on act_valid, saturating at all-ones.
REQ-018 SHALL increment raa by 1 on act_valid, saturating at 2^RAA_W-1.
REQ-019 SHALL set rfm_req=1 on the cycle after raa>=RAAIMT while the state is IDLE, and hold it until granted.
REQ-020 SHALL implement states IDLE, SCAN and ISSUE.
REQ-021 IDLE to SCAN transition: SHALL occur when rfm_req=1 and rfm_grant=1 at cycle T, with rfm_req=0, ptr=0, best_cnt=0 and best_idx=0 at T+1.
REQ-022 SCAN: SHALL read one entry per cycle, ptr 0 to NUM_ENTRY-1, replacing best only if cnt[ptr] > best_cnt (strictly), so the lowest index wins ties.
REQ-023 SCAN exit: SHALL go to ISSUE after the entry NUM_ENTRY-1 compare if best_cnt>0, with mit_valid=1 at T+NUM_ENTRY+1; if best_cnt=0 it SHALL instead go to IDLE with no mit_valid.
REQ-024 ISSUE: SHALL hold mit_idx and mit_cnt stable while mit_valid=1 and mit_ready=0.
REQ-025 On the ISSUE handshake: SHALL clear cnt[mit_idx] to 0, deassert mit_valid next cycle and return to IDLE.
REQ-026 On SCAN or ISSUE completion: SHALL set raa to max(raa-RAAIMT, 0), counting any activation in the same cycle after the subtraction.
REQ-027 Activations during SCAN/ISSUE: SHALL still update counters, and the scan SHALL use the value present on the cycle that entry is read.
REQ-028 Simultaneous clear and act_valid to the same index: SHALL leave the counter at 1.
REQ-029 SHALL keep mit_idx and mit_cnt at 0 whenever mit_valid=0.

Reset
REQ-030 When rst=1: SHALL set state=IDLE, all counters=0, raa=0, ptr=0, best=0, rfm_req=0, mit_valid=0, mit_idx=0, mit_cnt=0 and busy=0 on the next edge.
REQ-031 Reset during SCAN or ISSUE: SHALL abort the scan or issue and produce no mitigation transfer.
REQ-032 SHALL ignore act_valid in any cycle where rst=1.

Configuration
REQ-033 With macro RFM_SCHED_STAT_EN defined: SHALL add output mit_total, 16 bits, reset 0, which increments per mitigation handshake and wraps at 0xFFFF->0.
REQ-034 Without RFM_SCHED_STAT_EN: SHALL have no mit_total port and no associated logic.

Structure
REQ-035 Package rfm_pkg SHALL hold the NUM_ENTRY, CNT_SIZE, IDX_W and RAAIMT defaults and the state enum typedef.
REQ-036 SHALL use sub-module rfm_cnt_table, a counter array with one increment port, one clear port and one read port.
REQ-037 The scheduler FSM, raa, and scan logic SHALL stay in rfm_sched.

Verification
REQ-038 Reset with 31 acts to idx 5: rfm_req stays 0; the 32nd act gives rfm_req=1 next cycle.
REQ-039 With cnt[5]=20, cnt[9]=20 and cnt[40]=7, grant at T: mit_valid at T+65 with mit_idx=5, mit_cnt=20.
REQ-040 With mit_ready low for 10 cycles: mit_idx and mit_cnt remain stable; after the handshake cnt[5]=0 and raa=raa-32.
REQ-041 Act to idx 5 in the handshake cycle: cnt[5]=1 afterwards.
REQ-042 All counters 0 and forced grant: no mit_valid, and state returns to IDLE at T+65.
REQ-043 rst asserted at T+30 of a scan: all outputs 0 next cycle and no mitigation follows.
